// File: rtl/exe_stage_reg_alu.sv
// Execute stage: ALU with EXE_CMD decoding, NZCV status register,
// branch-target adder and a registered EX/MEM pipeline boundary with
// stall and flush. Branch outputs are combinational; everything else
// is registered one cycle after the inputs.
module exe_stage_reg_alu #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned REG_AW = 4,
  parameter int unsigned IMM_W  = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              valid_in,
  input  logic [WIDTH-1:0]  pc_in,
  input  logic [WIDTH-1:0]  instr_in,
  input  logic [3:0]        exe_cmd,
  input  logic [WIDTH-1:0]  val_rn,
  input  logic [WIDTH-1:0]  val2,
  input  logic [WIDTH-1:0]  val_rm,
  input  logic              s_in,
  input  logic              b_in,
  input  logic [IMM_W-1:0]  imm,
  input  logic              mem_r_in,
  input  logic              mem_w_in,
  input  logic              wb_en_in,
  input  logic [REG_AW-1:0] dest_in,
  output logic [WIDTH-1:0]  pc_out,
  output logic [WIDTH-1:0]  instr_out,
  output logic [WIDTH-1:0]  alu_result,
  output logic [WIDTH-1:0]  val_rm_out,
  output logic              mem_r_out,
  output logic              mem_w_out,
  output logic              wb_en_out,
  output logic              valid_out,
  output logic [REG_AW-1:0] dest_out,
  output logic [3:0]        status,
  output logic              branch_taken,
  output logic [WIDTH-1:0]  branch_addr
);

  localparam int unsigned EXT_W = WIDTH + 1;

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;

  // Status bit positions within {N,Z,C,V}
  localparam int unsigned ST_N = 3;
  localparam int unsigned ST_Z = 2;
  localparam int unsigned ST_C = 1;
  localparam int unsigned ST_V = 0;

  logic             c_flag;
  logic             is_arith;
  logic             is_logic;
  logic             is_sub;
  logic             carry_in;
  logic [WIDTH-1:0] opb_eff;
  logic [EXT_W-1:0] sum_ext;
  logic [WIDTH-1:0] alu_res;
  logic             res_n;
  logic             res_z;
  logic             res_c;
  logic             res_v;
  logic [3:0]       status_nxt;
  logic             status_we;
  logic             capture;
  logic [WIDTH-1:0] imm_sext;

  assign c_flag = status[ST_C];

  // Decode op class and prepare the adder operands (subtract = A + ~B + carry)
  always_comb begin
    is_arith = 1'b0;
    is_logic = 1'b0;
    is_sub   = 1'b0;
    carry_in = 1'b0;
    case (exe_cmd)
      CMD_ADD: begin
        is_arith = 1'b1;
      end
      CMD_ADC: begin
        is_arith = 1'b1;
        carry_in = c_flag;
      end
      CMD_SUB: begin
        is_arith = 1'b1;
        is_sub   = 1'b1;
        carry_in = 1'b1;
      end
      CMD_SBC: begin
        is_arith = 1'b1;
        is_sub   = 1'b1;
        carry_in = c_flag;
      end
      CMD_MOV, CMD_MVN, CMD_AND, CMD_ORR, CMD_EOR: begin
        is_logic = 1'b1;
      end
      default: begin
        is_arith = 1'b0;
        is_logic = 1'b0;
      end
    endcase
  end

  assign opb_eff = is_sub ? ~val2 : val2;

  // Shared WIDTH+1 adder; top bit is carry-out (NOT borrow when subtracting)
  always_comb begin
    sum_ext = {1'b0, val_rn} + {1'b0, opb_eff} + EXT_W'(carry_in);
  end

  // Result mux
  always_comb begin
    alu_res = '0;
    case (exe_cmd)
      CMD_MOV: alu_res = val2;
      CMD_MVN: alu_res = ~val2;
      CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: alu_res = sum_ext[WIDTH-1:0];
      CMD_AND: alu_res = val_rn & val2;
      CMD_ORR: alu_res = val_rn | val2;
      CMD_EOR: alu_res = val_rn ^ val2;
      default: alu_res = '0;
    endcase
  end

  // Flag generation; overflow when effective operands agree in sign but result differs
  always_comb begin
    res_n = alu_res[WIDTH-1];
    res_z = (alu_res == '0);
    res_c = sum_ext[WIDTH];
    res_v = (val_rn[WIDTH-1] == opb_eff[WIDTH-1]) &&
            (alu_res[WIDTH-1] != val_rn[WIDTH-1]);
    status_nxt = status;
    if (is_arith) begin
      status_nxt = {res_n, res_z, res_c, res_v};
    end else if (is_logic) begin
      status_nxt = {res_n, res_z, status[ST_C], status[ST_V]};
    end
  end

  assign capture   = ~stall & ~flush;
  assign status_we = s_in & valid_in & capture & (is_arith | is_logic);

  // Branch target: PC+4 plus sign-extended word offset, wraps modulo 2^WIDTH
  assign imm_sext     = WIDTH'($signed(imm));
  assign branch_addr  = pc_in + (imm_sext << 2);
  assign branch_taken = b_in & valid_in;

  // NZCV status register
  always_ff @(posedge clk) begin
    if (rst) begin
      status <= '0;
    end else if (status_we) begin
      status <= status_nxt;
    end
  end

  // EX/MEM control: flush clears, stall holds, bubbles carry no side effects
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out <= 1'b0;
      mem_r_out <= 1'b0;
      mem_w_out <= 1'b0;
      wb_en_out <= 1'b0;
    end else if (flush) begin
      valid_out <= 1'b0;
      mem_r_out <= 1'b0;
      mem_w_out <= 1'b0;
      wb_en_out <= 1'b0;
    end else if (!stall) begin
      valid_out <= valid_in;
      mem_r_out <= mem_r_in & valid_in;
      mem_w_out <= mem_w_in & valid_in;
      wb_en_out <= wb_en_in & valid_in;
    end
  end

  // EX/MEM data: captured only on a normal advance, held on stall or flush
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_out     <= '0;
      instr_out  <= '0;
      alu_result <= '0;
      val_rm_out <= '0;
      dest_out   <= '0;
    end else if (capture) begin
      pc_out     <= pc_in;
      instr_out  <= instr_in;
      alu_result <= alu_res;
      val_rm_out <= val_rm;
      dest_out   <= dest_in;
    end
  end

endmodule

// File: tb/tb_exe_stage_reg_alu.sv
// Bench for exe_stage_reg_alu: directed scenarios plus randomized traffic
// checked against a behavioural model using plain 64-bit arithmetic.
module tb_exe_stage_reg_alu;

  localparam int unsigned W  = 32;
  localparam int unsigned AW = 4;
  localparam int unsigned IW = 24;

  logic          clk;
  logic          rst, stall, flush, valid_in;
  logic [W-1:0]  pc_in, instr_in, val_rn, val2, val_rm;
  logic [3:0]    exe_cmd;
  logic          s_in, b_in, mem_r_in, mem_w_in, wb_en_in;
  logic [IW-1:0] imm;
  logic [AW-1:0] dest_in;
  logic [W-1:0]  pc_out, instr_out, alu_result, val_rm_out, branch_addr;
  logic          mem_r_out, mem_w_out, wb_en_out, valid_out, branch_taken;
  logic [AW-1:0] dest_out;
  logic [3:0]    status;

  exe_stage_reg_alu #(.WIDTH(W), .REG_AW(AW), .IMM_W(IW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_in(valid_in),
    .pc_in(pc_in), .instr_in(instr_in), .exe_cmd(exe_cmd), .val_rn(val_rn),
    .val2(val2), .val_rm(val_rm), .s_in(s_in), .b_in(b_in), .imm(imm),
    .mem_r_in(mem_r_in), .mem_w_in(mem_w_in), .wb_en_in(wb_en_in),
    .dest_in(dest_in), .pc_out(pc_out), .instr_out(instr_out),
    .alu_result(alu_result), .val_rm_out(val_rm_out), .mem_r_out(mem_r_out),
    .mem_w_out(mem_w_out), .wb_en_out(wb_en_out), .valid_out(valid_out),
    .dest_out(dest_out), .status(status), .branch_taken(branch_taken),
    .branch_addr(branch_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state (expected registered outputs)
  logic [W-1:0]  m_pc, m_instr, m_res, m_rm;
  logic          m_mr, m_mw, m_wb, m_valid;
  logic [AW-1:0] m_dest;
  logic [3:0]    m_status;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural ALU from the op definitions, using wide integer arithmetic
  function automatic void ref_alu(input logic [3:0] cmd, input logic [W-1:0] a,
                                  input logic [W-1:0] b, input logic cin,
                                  output logic [W-1:0] res, output logic arith,
                                  output logic known, output logic c, output logic v);
    longint ua, ub, sa, sb, u, s, br;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    res = '0; arith = 1'b0; known = 1'b1; c = 1'b0; v = 1'b0;
    u = 0; s = 0; br = 0;
    case (cmd)
      4'd1: res = b;
      4'd9: res = ~b;
      4'd6: res = a & b;
      4'd7: res = a | b;
      4'd8: res = a ^ b;
      4'd2, 4'd3: begin
        arith = 1'b1;
        br = (cmd == 4'd3) ? longint'(cin) : 0;
        u = ua + ub + br;
        s = sa + sb + br;
        c = (u >= 64'sh1_0000_0000);
        res = u[W-1:0];
      end
      4'd4, 4'd5: begin
        arith = 1'b1;
        br = (cmd == 4'd5 && cin == 1'b0) ? 1 : 0;
        u = ua - ub - br;
        s = sa - sb - br;
        c = (ua >= ub + br);
        res = u[W-1:0];
      end
      default: known = 1'b0;
    endcase
    v = arith && (s > 64'sd2147483647 || s < -64'sd2147483648);
  endfunction

  // Advance model by one clock edge using the inputs currently applied
  task automatic model_step();
    logic [W-1:0] r;
    logic ar, kn, c, v;
    ref_alu(exe_cmd, val_rn, val2, m_status[1], r, ar, kn, c, v);
    if (rst) begin
      m_pc = '0; m_instr = '0; m_res = '0; m_rm = '0; m_dest = '0;
      m_mr = 0; m_mw = 0; m_wb = 0; m_valid = 0; m_status = '0;
    end else if (flush) begin
      m_valid = 0; m_mr = 0; m_mw = 0; m_wb = 0;
    end else if (!stall) begin
      m_pc = pc_in; m_instr = instr_in; m_res = r; m_rm = val_rm; m_dest = dest_in;
      m_valid = valid_in;
      m_mr = mem_r_in && valid_in;
      m_mw = mem_w_in && valid_in;
      m_wb = wb_en_in && valid_in;
      if (s_in && valid_in && kn)
        m_status = ar ? {r[W-1], r == 0, c, v} : {r[W-1], r == 0, m_status[1:0]};
    end
  endtask

  task automatic rand_inputs();
    rst = 0; stall = 0; flush = 0;
    valid_in = 1'($urandom); pc_in = $urandom; instr_in = $urandom;
    exe_cmd = 4'($urandom); val_rn = $urandom; val2 = $urandom; val_rm = $urandom;
    s_in = 1'($urandom); b_in = 1'($urandom); imm = IW'($urandom);
    mem_r_in = 1'($urandom); mem_w_in = 1'($urandom); wb_en_in = 1'($urandom);
    dest_in = AW'($urandom);
  endtask

  task automatic set_op(input logic [3:0] cmd, input logic [W-1:0] a, input logic [W-1:0] b);
    rand_inputs();
    valid_in = 1; s_in = 1; exe_cmd = cmd; val_rn = a; val2 = b;
  endtask

  // One clock: check branch outputs, step the model, then compare registers
  task automatic cycle();
    longint isx;
    logic [W-1:0] exp_ba;
    #1;
    isx = longint'($signed(imm));
    exp_ba = W'(longint'(pc_in) + isx * 4);
    check("branch_addr", branch_addr, exp_ba);
    check("branch_taken", branch_taken, b_in && valid_in);
    model_step();
    @(posedge clk);
    #1;
    check("pc_out", pc_out, m_pc);
    check("instr_out", instr_out, m_instr);
    check("alu_result", alu_result, m_res);
    check("val_rm_out", val_rm_out, m_rm);
    check("dest_out", dest_out, m_dest);
    check("valid_out", valid_out, m_valid);
    check("mem_r_out", mem_r_out, m_mr);
    check("mem_w_out", mem_w_out, m_mw);
    check("wb_en_out", wb_en_out, m_wb);
    check("status", status, m_status);
  endtask

  initial begin
    m_status = '0;
    rand_inputs();
    @(posedge clk);
    #1;
    // Reset for two cycles with random inputs
    for (int i = 0; i < 2; i++) begin
      rand_inputs(); rst = 1; stall = 1'($urandom); flush = 1'($urandom);
      cycle();
    end
    check("reset_status", status, 4'h0);
    check("reset_valid", valid_out, 1'b0);
    check("reset_alu", alu_result, 32'h0);

    // ADD overflow
    set_op(4'b0010, 32'h7FFF_FFFF, 32'h1);
    cycle();
    check("add_result", alu_result, 32'h8000_0000);
    check("add_flags", status, 4'b1001);

    // SUB to zero, then SBC with C=1
    set_op(4'b0100, 32'd5, 32'd5);
    cycle();
    check("sub_result", alu_result, 32'h0);
    check("sub_flags", status, 4'b0110);
    set_op(4'b0101, 32'd3, 32'd1);
    cycle();
    check("sbc_c1_result", alu_result, 32'd2);

    // Clear C with a small ADD, then SBC borrows
    set_op(4'b0010, 32'd1, 32'd1);
    cycle();
    check("add_c0_flags", status, 4'b0000);
    set_op(4'b0101, 32'd3, 32'd1);
    cycle();
    check("sbc_c0_result", alu_result, 32'd1);

    // Stall 3 cycles with changing inputs
    for (int i = 0; i < 3; i++) begin
      rand_inputs(); stall = 1; s_in = 1; valid_in = 1; exe_cmd = 4'b0010;
      cycle();
      check("stall_alu_hold", alu_result, 32'd1);
    end
    // Stall + flush: bubble, status unchanged
    set_op(4'b0010, 32'hFFFF_FFFF, 32'd1);
    stall = 1; flush = 1; wb_en_in = 1;
    cycle();
    check("sf_valid", valid_out, 1'b0);
    check("sf_wb_en", wb_en_out, 1'b0);

    // Branch target with negative offset
    rand_inputs();
    pc_in = 32'h100; imm = 24'hFFFFFE; b_in = 1; valid_in = 1;
    #1;
    check("br_addr_neg", branch_addr, 32'hF8);
    check("br_taken_v1", branch_taken, 1'b1);
    valid_in = 0;
    #1;
    check("br_taken_v0", branch_taken, 1'b0);
    cycle();

    // Set C=1,V=1 then logic op keeps them
    set_op(4'b0010, 32'h8000_0000, 32'h8000_0000);
    cycle();
    check("cv_set_flags", status, 4'b0111);
    set_op(4'b0110, 32'h0000_00F0, 32'h0000_000F);
    cycle();
    check("and_keeps_cv", status, 4'b0111);

    // Randomized traffic with occasional stall, flush and reset
    for (int i = 0; i < 600; i++) begin
      rand_inputs();
      stall = ($urandom_range(0, 99) < 20);
      flush = ($urandom_range(0, 99) < 10);
      rst   = ($urandom_range(0, 99) < 3);
      case ($urandom_range(0, 5))
        0: val_rn = 32'h7FFF_FFFF;
        1: val2 = 32'h8000_0000;
        2: val2 = val_rn;
        default: ;
      endcase
      if ($urandom_range(0, 3) != 0) exe_cmd = 4'($urandom_range(1, 9));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/exe_stage_reg_alu.md
Name: exe_stage_reg_alu

Overview:
- Parametrised execute stage: ALU with ARM-style EXE_CMD decoding, NZCV status register, branch-target adder, and a registered EX/MEM pipeline boundary with stall and flush.
- Sits between the ID/EX register and the MEM stage.
- Forwards PC and instruction like the earlier pass-through stage, but now computes and registers results.

Parameters:
- WIDTH, 32, data/PC/instruction width.
- REG_AW, 4, destination register address width.
- IMM_W, 24, branch immediate width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- stall  in  1  hold EX/MEM register and status.
- flush  in  1  insert bubble into EX/MEM register.
- valid_in  in  1  incoming instruction valid.
- pc_in  in  WIDTH  PC+4 of instruction.
- instr_in  in  WIDTH  instruction word.
- exe_cmd  in  4  ALU op.
- val_rn  in  WIDTH  operand A.
- val2  in  WIDTH  operand B, already shifted/immediate.
- val_rm  in  WIDTH  store data.
- s_in  in  1  update flags.
- b_in  in  1  branch.
- imm  in  IMM_W  signed word offset.
- mem_r_in, mem_w_in, wb_en_in  in  1 each  control.
- dest_in  in  REG_AW  destination.
- pc_out, instr_out, alu_result, val_rm_out  out  WIDTH  registered.
- mem_r_out, mem_w_out, wb_en_out, valid_out  out  1  registered.
- dest_out  out  REG_AW  registered.
- status  out  4  registered {N,Z,C,V}.
- branch_taken  out  1  combinational: b_in & valid_in.
- branch_addr  out  WIDTH  combinational: pc_in + (sext(imm) << 2), truncated to WIDTH.

Behaviour:
- Reset (rst=1 at a clk edge): all registered outputs and status go to 0.
- ALU (combinational, WIDTH+1 internal for carry):
  - 0001 MOV: B.
  - 1001 MVN: ~B.
  - 0010 ADD: A+B.
  - 0011 ADC: A+B+C.
  - 0100 SUB: A−B.
  - 0101 SBC: A−B−(~C).
  - 0110 AND.
  - 0111 ORR.
  - 1000 EOR.
  - Any other code: result 0, flags not updated.
- Flags:
  - N = result[WIDTH-1]; Z = (result==0).
  - Arithmetic ops: C = carry-out for add; C = NOT borrow for sub. V = signed overflow for add (A,B same sign, result differs) and for sub (A,B differ in sign, result sign differs from A).
  - Logic/MOV/MVN: C and V unchanged.
- Status write: only when s_in & valid_in & ~stall & ~flush; takes effect at the edge, visible the next cycle. ADC/SBC use the currently registered C.
- EX/MEM register update rules:
  - ~stall & ~flush: capture all *_in / computed values; valid_out = valid_in. If valid_in=0, control outs (mem_r/mem_w/wb_en) are forced to 0.
  - flush (with or without stall; flush has priority): valid_out, mem_r_out, mem_w_out, wb_en_out = 0. Data outputs are don't-care and are required to hold their previous values.
  - stall & ~flush: every registered output and status holds.
- Latency: one cycle from inputs to registered outputs. Branch outputs have zero latency.
- Wrap-around: branch_addr and ALU results wrap modulo 2^WIDTH; no exceptions.
- Reset mid-stall or mid-flush: reset wins over both.

Test Plan:
- Reset: assert rst for 2 cycles with random inputs -> all outputs and status 0, valid_out 0.
- ADD with flags: exe_cmd=0010, A=0x7FFFFFFF, B=1, s_in=1 -> next cycle alu_result=0x80000000, status=N1 Z0 C0 V1.
- SUB/SBC chain:
  - SUB A=5, B=5, s_in=1 -> result 0, status Z1 C1.
  - Next cycle SBC A=3, B=1 -> result 2.
  - With C=0 beforehand, SBC A=3, B=1 -> result 1.
- Stall/flush priority:
  - stall=1 for 3 cycles with changing inputs -> outputs and status frozen.
  - stall=1 and flush=1 -> valid_out=0, wb_en_out=0, status unchanged.
- Branch: pc_in=0x100, imm=0xFFFFFE (−2), b_in=1, valid_in=1 -> branch_addr=0xF8, branch_taken=1 same cycle. With valid_in=0 -> branch_taken=0.
- Logic preserves C/V: set C=1, V=1 via arithmetic, then AND s_in=1 with result 0 -> status N0 Z1 C1 V1.
